instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_if.sv | 35 +++
 rtl/instruction_fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel,
// backend redirect, and the decode-stage handoff.
interface instruction_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_fetch_fault;

  // The fetch unit itself.
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  redirect_valid, redirect_pc,
    output id_valid, id_instr, id_pc, id_fetch_fault,
    input  id_ready
  );

  // Memory, backend and decoder side.
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output redirect_valid, redirect_pc,
    input  id_valid, id_instr, id_pc, id_fetch_fault,
    output id_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues one word fetch at a time, buffers the
// returned instructions in a small FIFO for decode, and restarts fetch on a
// backend redirect. An access fault is delivered as a faulting NOP and
// stops fetching until the next redirect.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic                      clk,
  input logic                      reset_n,
  instruction_fetch_unit_if.master bus
);
  localparam int unsigned      PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {REQ, WAIT, DRAIN, HALT} state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic             req_valid_q, req_valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic             handshake;
  logic             push;
  logic             pop;
  logic [31:0]      push_instr;
  logic             push_fault;

  logic [31:0]      slot_pc    [FIFO_DEPTH];
  logic [31:0]      slot_instr [FIFO_DEPTH];
  logic             slot_fault [FIFO_DEPTH];

  // Redirect targets are word aligned; the two low bits are dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  assign handshake = req_valid_q & bus.imem_req_ready;

  // Next fetch state, fetch pointer and buffer write request.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    push          = 1'b0;
    push_instr    = bus.imem_rsp_data;
    push_fault    = 1'b0;
    case (state_q)
      REQ: begin
        if (handshake) begin
          state_d       = WAIT;
          inflight_pc_d = fetch_pc_q;
          fetch_pc_d    = fetch_pc_q + 32'd4;
        end
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          push = 1'b1;
          if (bus.imem_rsp_err) begin
            push_instr = NOP_INSTR;
            push_fault = 1'b1;
            state_d    = HALT;
          end else begin
            state_d = REQ;
          end
        end
      end
      DRAIN: begin
        // The answer to a request made before the redirect is thrown away.
        if (bus.imem_rsp_valid) begin
          state_d = REQ;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = REQ;
      end
    endcase
    // A redirect overrides everything; a response in the same cycle is dropped,
    // and a request still owed an answer sends the FSM to DRAIN.
    if (bus.redirect_valid) begin
      push       = 1'b0;
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      if (((state_q == WAIT || state_q == DRAIN) && !bus.imem_rsp_valid) ||
          (state_q == REQ && handshake)) begin
        state_d = DRAIN;
      end else begin
        state_d = REQ;
      end
    end
  end

  // Buffer occupancy; a redirect flushes and overrides any pop.
  always_comb begin
    pop      = (count_q != '0) & bus.id_ready & ~bus.redirect_valid;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.redirect_valid) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end
    // Only REQ issues and nothing is outstanding there, so free space in the
    // buffer is the whole issue condition.
    req_valid_d = (state_d == REQ) && (count_d < FULL_CNT);
  end

  // FSM, fetch pointer and registered request valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= REQ;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      req_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      req_valid_q   <= req_valid_d;
    end
  end

  // Buffer pointers and entry count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        fault_q;

    // Capture the pushed entry when the write pointer selects this slot.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pc_q    <= '0;
        instr_q <= '0;
        fault_q <= 1'b0;
      end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
        pc_q    <= inflight_pc_q;
        instr_q <= push_instr;
        fault_q <= push_fault;
      end
    end

    assign slot_pc[gi]    = pc_q;
    assign slot_instr[gi] = instr_q;
    assign slot_fault[gi] = fault_q;
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.id_valid       = (count_q != '0);
  assign bus.id_pc          = slot_pc[rd_ptr_q];
  assign bus.id_instr       = slot_instr[rd_ptr_q];
  assign bus.id_fetch_fault = slot_fault[rd_ptr_q];
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus a randomized run
// scored against a program-order model of the delivered instruction stream.
module tb_instruction_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  instruction_fetch_unit_if ifc ();

  instruction_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (ifc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory responder state: at most one request being answered.
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_wait = 0;
  bit          fault_en = 1'b0;
  logic [31:0] fault_addr = '0;
  bit          rand_faults = 1'b0;

  typedef struct {
    bit          rv, hs, ovl, idv, pop, rsp;
    logic [31:0] ra, ipc, iins;
    logic        iflt;
  } obs_t;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit is_fault(input logic [31:0] a);
    return (fault_en && a == fault_addr) || (rand_faults && a[8:2] == 7'h2B);
  endfunction

  task automatic drive_idle();
    ifc.imem_req_ready = 1'b0;
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_data  = '0;
    ifc.imem_rsp_err   = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = '0;
    ifc.id_ready       = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset_n = 1'b0;
    pend    = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, observe outputs before the edge, then
  // advance the memory responder. Entered and left 1ns after a rising edge.
  task automatic tick(input bit rdy, input bit idr, input bit redir,
                      input logic [31:0] rpc, input int lat, output obs_t o);
    bit rsp_now;
    ifc.imem_req_ready = rdy;
    ifc.id_ready       = idr;
    ifc.redirect_valid = redir;
    ifc.redirect_pc    = rpc;
    rsp_now            = pend && (pend_wait == 0);
    ifc.imem_rsp_valid = rsp_now;
    if (rsp_now) begin
      ifc.imem_rsp_data = mem_word(pend_addr);
      ifc.imem_rsp_err  = is_fault(pend_addr);
    end else begin
      ifc.imem_rsp_data = $urandom;
      ifc.imem_rsp_err  = 1'($urandom);
    end
    #1;
    o.rv   = ifc.imem_req_valid;
    o.ra   = ifc.imem_req_addr;
    o.hs   = o.rv && rdy;
    o.ovl  = o.hs && pend;
    o.idv  = ifc.id_valid;
    o.ipc  = ifc.id_pc;
    o.iins = ifc.id_instr;
    o.iflt = ifc.id_fetch_fault;
    o.pop  = o.idv && idr && !redir;
    o.rsp  = rsp_now;
    @(posedge clk);
    #1;
    if (rsp_now) pend = 1'b0;
    else if (pend) pend_wait--;
    if (o.hs) begin
      pend      = 1'b1;
      pend_addr = o.ra;
      pend_wait = lat - 1;
    end
  endtask

  task automatic test_reset();
    obs_t o;
    drive_idle();
    #1 reset_n = 1'b0;
    #2;
    checks++; if (ifc.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", ifc.imem_req_valid); end
    checks++; if (ifc.id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b want 0", ifc.id_valid); end
    checks++; if (ifc.id_instr !== 32'h0) begin errors++; $display("FAIL reset_id_instr: got %h want 0", ifc.id_instr); end
    checks++; if (ifc.id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc: got %h want 0", ifc.id_pc); end
    checks++; if (ifc.id_fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_id_fault: got %b want 0", ifc.id_fetch_fault); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0, '0, 1, o);
    checks++; if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== RESET_PC) begin errors++;
      $display("FAIL first_request: got valid=%b addr=%h want valid=1 addr=%h", ifc.imem_req_valid, ifc.imem_req_addr, RESET_PC); end
    $display("test_reset done: errors=%0d", errors);
  endtask

  task automatic test_first_fetch();
    obs_t o;
    int hs_cyc = -1;
    int late_pops = 0;
    int order_bad = 0;
    logic [31:0] p_pc[$];
    logic [31:0] p_ins[$];
    int p_cyc[$];
    do_reset();
    for (int c = 0; c < 40; c++) begin
      tick(1'b1, 1'b1, 1'b0, '0, 1, o);
      if (o.hs && hs_cyc < 0) hs_cyc = c;
      if (o.pop) begin p_pc.push_back(o.ipc); p_ins.push_back(o.iins); p_cyc.push_back(c); end
    end
    checks++;
    if (p_pc.size() < 2 || hs_cyc < 0) begin
      errors++; $display("FAIL first_fetch_count: got pops=%0d want >=2", p_pc.size());
    end else begin
      checks++; if (p_cyc[0] - hs_cyc != 2) begin errors++;
        $display("FAIL first_fetch_latency: got %0d cycles want 2 after request cycle", p_cyc[0] - hs_cyc); end
      checks++; if (p_pc[0] !== 32'h0 || p_ins[0] !== 32'h0050_0093) begin errors++;
        $display("FAIL first_fetch_0: got pc=%h instr=%h want pc=0 instr=00500093", p_pc[0], p_ins[0]); end
      checks++; if (p_pc[1] !== 32'h4 || p_ins[1] !== 32'h00A0_0113) begin errors++;
        $display("FAIL first_fetch_1: got pc=%h instr=%h want pc=4 instr=00a00113", p_pc[1], p_ins[1]); end
      for (int k = 0; k < p_pc.size(); k++) begin
        if (p_pc[k] !== RESET_PC + 32'(4 * k) || p_ins[k] !== mem_word(RESET_PC + 32'(4 * k))) order_bad++;
        if (p_cyc[k] >= 20) late_pops++;
      end
      checks++; if (order_bad != 0) begin errors++; $display("FAIL stream_order: got %0d bad entries want 0", order_bad); end
      checks++; if (late_pops != 10) begin errors++; $display("FAIL throughput: got %0d instr in 20 cycles want 10", late_pops); end
    end
    $display("test_first_fetch done: errors=%0d", errors);
  endtask

  task automatic test_backpressure();
    obs_t o;
    int hs_n = 0;
    int changed = 0;
    bit have = 1'b0;
    logic [31:0] h_pc = '0, h_ins = '0;
    logic [31:0] p_pc[$];
    int bad = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick(1'b1, 1'b0, 1'b0, '0, 1, o);
      if (o.hs) hs_n++;
      if (o.idv) begin
        if (have && (o.ipc !== h_pc || o.iins !== h_ins)) changed++;
        if (!have) begin have = 1'b1; h_pc = o.ipc; h_ins = o.iins; end
      end
    end
    checks++; if (hs_n != DEPTH) begin errors++; $display("FAIL stall_fetches: got %0d want %0d", hs_n, DEPTH); end
    checks++; if (ifc.imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid: got %b want 0", ifc.imem_req_valid); end
    checks++; if (ifc.id_valid !== 1'b1 || ifc.id_pc !== RESET_PC) begin errors++;
      $display("FAIL stall_head: got valid=%b pc=%h want valid=1 pc=%h", ifc.id_valid, ifc.id_pc, RESET_PC); end
    checks++; if (changed != 0) begin errors++; $display("FAIL stall_stable: got %0d head changes want 0", changed); end
    for (int c = 0; c < DEPTH + 3; c++) begin
      tick(1'b0, 1'b1, 1'b0, '0, 1, o);
      if (o.pop) p_pc.push_back(o.ipc);
    end
    checks++; if (p_pc.size() != DEPTH) begin errors++; $display("FAIL drain_count: got %0d want %0d", p_pc.size(), DEPTH); end
    foreach (p_pc[k]) if (p_pc[k] !== RESET_PC + 32'(4 * k)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL drain_order: got %0d out-of-order want 0", bad); end
    $display("test_backpressure done: errors=%0d", errors);
  endtask

  task automatic test_redirect_wait();
    obs_t o;
    bit got = 1'b0;
    int rsp_cyc = -1, hs_cyc = -1;
    logic [31:0] hs_addr = '0;
    bit popped = 1'b0;
    logic [31:0] f_pc = '0, f_ins = '0;
    logic f_flt = 1'b0;
    do_reset();
    for (int c = 0; c < 10 && !got; c++) begin
      tick(1'b1, 1'b1, 1'b0, '0, 3, o);
      got = o.hs;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL redirect_setup: got no request want one within 10 cycles");
    end else begin
      tick(1'b1, 1'b1, 1'b1, 32'h0000_0103, 1, o);
      for (int c = 0; c < 20; c++) begin
        tick(1'b1, 1'b1, 1'b0, '0, 1, o);
        if (c == 0) begin
          checks++; if (o.idv !== 1'b0) begin errors++; $display("FAIL redirect_no_stale: got id_valid=%b want 0", o.idv); end
        end
        if (o.rsp && rsp_cyc < 0) rsp_cyc = c;
        if (o.hs && hs_cyc < 0) begin hs_cyc = c; hs_addr = o.ra; end
        if (o.pop && !popped) begin popped = 1'b1; f_pc = o.ipc; f_ins = o.iins; f_flt = o.iflt; end
      end
      checks++; if (hs_addr !== 32'h100 || hs_cyc < 0) begin errors++; $display("FAIL redirect_addr: got %h want 00000100", hs_addr); end
      checks++; if (hs_cyc <= rsp_cyc) begin errors++;
        $display("FAIL redirect_drain: got request at %0d stale response at %0d want request later", hs_cyc, rsp_cyc); end
      checks++; if (!popped || f_pc !== 32'h100 || f_ins !== mem_word(32'h100) || f_flt !== 1'b0) begin errors++;
        $display("FAIL redirect_first_instr: got pc=%h instr=%h want pc=00000100 instr=%h", f_pc, f_ins, mem_word(32'h100)); end
    end
    $display("test_redirect_wait done: errors=%0d", errors);
  endtask

  task automatic test_fault();
    obs_t o;
    logic [31:0] hs_a[$];
    logic [31:0] p_pc[$], p_ins[$];
    logic p_f[$];
    bit got = 1'b0;
    do_reset();
    fault_en   = 1'b1;
    fault_addr = 32'h8;
    for (int c = 0; c < 30; c++) begin
      tick(1'b1, 1'b1, 1'b0, '0, 1, o);
      if (o.hs) hs_a.push_back(o.ra);
      if (o.pop) begin p_pc.push_back(o.ipc); p_ins.push_back(o.iins); p_f.push_back(o.iflt); end
    end
    checks++; if (hs_a.size() != 3) begin errors++; $display("FAIL fault_halt: got %0d requests want 3", hs_a.size()); end
    checks++;
    if (p_pc.size() != 3) begin
      errors++; $display("FAIL fault_entries: got %0d want 3", p_pc.size());
    end else begin
      checks++; if (p_pc[2] !== 32'h8 || p_ins[2] !== NOP || p_f[2] !== 1'b1) begin errors++;
        $display("FAIL fault_entry: got pc=%h instr=%h fault=%b want pc=8 instr=00000013 fault=1", p_pc[2], p_ins[2], p_f[2]); end
      checks++; if (p_f[0] !== 1'b0 || p_f[1] !== 1'b0) begin errors++; $display("FAIL fault_clean: got %b%b want 00", p_f[0], p_f[1]); end
    end
    fault_en = 1'b0;
    tick(1'b1, 1'b1, 1'b1, 32'h40, 1, o);
    for (int c = 0; c < 10 && !got; c++) begin
      tick(1'b1, 1'b1, 1'b0, '0, 1, o);
      got = o.hs;
    end
    checks++; if (!got || o.ra !== 32'h40) begin errors++; $display("FAIL fault_resume: got req=%b addr=%h want req=1 addr=00000040", got, o.ra); end
    $display("test_fault done: errors=%0d", errors);
  endtask

  task automatic test_wrap();
    obs_t o;
    logic [31:0] hs_a[$];
    logic [31:0] p_pc[$];
    do_reset();
    tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1, o);
    for (int c = 0; c < 12; c++) begin
      tick(1'b1, 1'b1, 1'b0, '0, 1, o);
      if (o.hs) hs_a.push_back(o.ra);
      if (o.pop) p_pc.push_back(o.ipc);
    end
    checks++;
    if (hs_a.size() < 2 || p_pc.size() < 2) begin
      errors++; $display("FAIL wrap_count: got req=%0d pops=%0d want >=2 each", hs_a.size(), p_pc.size());
    end else begin
      checks++; if (hs_a[0] !== 32'hFFFF_FFFC || hs_a[1] !== 32'h0) begin errors++;
        $display("FAIL wrap_addr: got %h,%h want fffffffc,00000000", hs_a[0], hs_a[1]); end
      checks++; if (p_pc[0] !== 32'hFFFF_FFFC || p_pc[1] !== 32'h0) begin errors++;
        $display("FAIL wrap_pc: got %h,%h want fffffffc,00000000", p_pc[0], p_pc[1]); end
    end
    $display("test_wrap done: errors=%0d", errors);
  endtask

  task automatic test_async_reset();
    obs_t o;
    int hs_n = 0;
    bit popped = 1'b0;
    logic [31:0] first_hs = 32'hDEAD_BEEF;
    bit have_hs = 1'b0;
    logic [31:0] f_pc = '0, f_ins = '0;
    do_reset();
    for (int c = 0; c < 12 && hs_n < 2; c++) begin
      tick(1'b1, 1'b0, 1'b0, '0, 3, o);
      if (o.hs) hs_n++;
    end
    checks++; if (hs_n != 2 || ifc.id_valid !== 1'b1) begin errors++;
      $display("FAIL areset_setup: got requests=%0d id_valid=%b want 2 and 1", hs_n, ifc.id_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (ifc.imem_req_valid !== 1'b0 || ifc.id_valid !== 1'b0) begin errors++;
      $display("FAIL areset_valids: got req=%b id=%b want 0 0", ifc.imem_req_valid, ifc.id_valid); end
    checks++; if (ifc.id_instr !== 32'h0 || ifc.id_pc !== 32'h0 || ifc.id_fetch_fault !== 1'b0) begin errors++;
      $display("FAIL areset_id: got instr=%h pc=%h fault=%b want zeros", ifc.id_instr, ifc.id_pc, ifc.id_fetch_fault); end
    pend = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int c = 0; c < 12 && !popped; c++) begin
      tick(1'b1, 1'b1, 1'b0, '0, 1, o);
      if (o.hs && !have_hs) begin have_hs = 1'b1; first_hs = o.ra; end
      if (o.pop) begin popped = 1'b1; f_pc = o.ipc; f_ins = o.iins; end
    end
    checks++; if (first_hs !== RESET_PC) begin errors++; $display("FAIL areset_restart: got %h want %h", first_hs, RESET_PC); end
    checks++; if (!popped || f_pc !== RESET_PC || f_ins !== mem_word(RESET_PC)) begin errors++;
      $display("FAIL areset_first_instr: got pc=%h instr=%h want pc=%h instr=%h", f_pc, f_ins, RESET_PC, mem_word(RESET_PC)); end
    $display("test_async_reset done: errors=%0d", errors);
  endtask

  // Random traffic: the delivered stream must follow program order from the
  // last redirect target, faults deliver a NOP and then silence.
  task automatic test_random();
    obs_t o;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_ins;
    logic        exp_f;
    bit halted = 1'b0;
    bit hold_id = 1'b0, hold_req = 1'b0;
    logic [31:0] h_pc = '0, h_ins = '0, h_ra = '0;
    logic h_f = 1'b0;
    bit rdy, idr, redir;
    logic [31:0] rpc;
    int pops = 0;
    do_reset();
    rand_faults = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      idr   = ($urandom_range(0, 2) != 0);
      redir = ($urandom_range(0, 15) == 0);
      rpc   = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 1023)) : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      tick(rdy, idr, redir, rpc, $urandom_range(1, 3), o);
      if (hold_id) begin
        checks++;
        if (o.idv !== 1'b1 || o.ipc !== h_pc || o.iins !== h_ins || o.iflt !== h_f) begin errors++;
          $display("FAIL rand_id_stable: cycle %0d got pc=%h instr=%h want pc=%h instr=%h", c, o.ipc, o.iins, h_pc, h_ins); end
      end
      if (hold_req && o.rv) begin
        checks++;
        if (o.ra !== h_ra) begin errors++; $display("FAIL rand_addr_stable: cycle %0d got %h want %h", c, o.ra, h_ra); end
      end
      if (o.hs) begin
        checks++;
        if (o.ovl || halted) begin errors++;
          $display("FAIL rand_request: cycle %0d got request (outstanding=%b halted=%b) want none", c, o.ovl, halted); end
      end
      if (redir) begin
        exp_pc = {rpc[31:2], 2'b00};
        halted = 1'b0;
      end else if (o.pop) begin
        pops++;
        exp_f   = is_fault(exp_pc);
        exp_ins = exp_f ? NOP : mem_word(exp_pc);
        checks++;
        if (halted || o.ipc !== exp_pc || o.iins !== exp_ins || o.iflt !== exp_f) begin errors++;
          $display("FAIL rand_stream: cycle %0d got pc=%h instr=%h fault=%b want pc=%h instr=%h fault=%b halted=%b",
                   c, o.ipc, o.iins, o.iflt, exp_pc, exp_ins, exp_f, halted); end
        if (exp_f) halted = 1'b1;
        exp_pc = exp_pc + 32'd4;
      end
      hold_id  = o.idv && !idr && !redir;
      h_pc     = o.ipc;
      h_ins    = o.iins;
      h_f      = o.iflt;
      hold_req = o.rv && !rdy && !redir;
      h_ra     = o.ra;
    end
    rand_faults = 1'b0;
    checks++; if (pops < 100) begin errors++; $display("FAIL rand_progress: got %0d instr want >=100", pops); end
    $display("test_random done: %0d instructions, errors=%0d", pops, errors);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect_wait();
    test_fault();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
